mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between the fetch stage (I port) and the memory stage (D port).
- Sequences one bus transaction at a time and passes responses back to the granted port.
- Raises per-stage stall requests that the hazard controller converts into stall_F / stall_M.
- Data port has priority; an instruction-port starvation counter guarantees forward progress.

Parameters:
- ADDR_W, 32, address width of ports and bus.
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits.
- MAX_WAIT, 4, cycles the I port may wait before it takes priority over D (1..2^WAIT_W-1).
- WAIT_W, 3, width of the starvation counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid with i_ack
- i_ack  out  1  fetch transaction complete (1-cycle pulse)
- d_req  in  1  memory-stage request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  data transaction complete (1-cycle pulse)
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_wstrb  out  DATA_W/8  bus byte enables
- bus_rdata  in  DATA_W  bus read data, valid with bus_ack
- bus_ack  in  1  slave completes the current transaction this cycle
- stall_req_F  out  1  fetch must stall
- stall_req_M  out  1  memory stage must stall

Behaviour:
- State machine: IDLE, GNT_I, GNT_D. The state register and the wait counter are the only sequential elements.
- Reset (async assert, sync-released use): state = IDLE, wait_cnt = 0.
  - All outputs are combinational from state and inputs. During reset: bus_req = 0, bus_we = 0, bus_addr/wdata/wstrb = 0, i_ack = d_ack = 0.
  - stall_req_F = i_req; stall_req_M = d_req.
- Arbitration function arb(i, d):
  - d & ~(i & wait_cnt >= MAX_WAIT) -> GNT_D
  - else i -> GNT_I
  - else IDLE.
- IDLE: bus_req = 0. Next state = arb(i_req, d_req). A request seen in cycle N drives bus_req in cycle N+1, so the minimum latency is req-to-ack of 2 cycles.
- GNT_x: bus_req = 1; bus_we/addr/wdata/wstrb are muxed from the granted port.
  - For GNT_I: bus_we = 0, bus_wstrb = 0, bus_wdata = 0.
  - Outputs are held stable until bus_ack.
- On bus_ack in GNT_x: x_ack = 1 and x_rdata = bus_rdata in the same cycle. The non-granted port sees ack = 0 and rdata = 0.
  - Next state = arb with the completing port's req masked to 0. This gives back-to-back grants to the other port with no IDLE bubble.
  - Otherwise, state is held.
- bus_ack is ignored in IDLE: no ack is generated and the state is unchanged.
- Stalls: stall_req_F = i_req & ~i_ack; stall_req_M = d_req & ~d_ack.
- Wait counter:
  - Increments (saturating at 2^WAIT_W-1) each cycle i_req = 1 and state != GNT_I.
  - Cleared to 0 in any cycle state == GNT_I.
- Simultaneous i_req and d_req in IDLE: D wins unless wait_cnt >= MAX_WAIT.
- Request withdrawal: dropping req before ack is illegal. The arbiter completes the transaction regardless and still pulses ack.
- Reset mid-transaction: the state returns to IDLE immediately. The in-flight bus transaction is abandoned and bus_req drops asynchronously.

Test Plan:
- Lone fetch:
  - i_req = 1, addr = 0x100 at cycle 0; slave acks at cycle 3 with 0xDEADBEEF.
  - Required: bus_req = 1 in cycles 1-3, bus_addr = 0x100, i_ack and i_rdata = 0xDEADBEEF at cycle 3, stall_req_F = 1 in cycles 0-2, state IDLE at cycle 4.
- Contention:
  - i_req and d_req (store, addr 0x2000, wdata 0x55, wstrb 0x1) both at cycle 0; slave acks after 1 cycle.
  - Required: D granted at cycle 1, d_ack at cycle 2, GNT_I at cycle 3 with no IDLE gap, i_ack at cycle 4.
- Starvation, MAX_WAIT = 4:
  - i_req held, d_req reasserted immediately after every d_ack, each D transaction 2 cycles.
  - Required: once wait_cnt reaches 4, the next arbitration grants I; i_ack occurs within 4 + 2 + 2 cycles.
- Spurious bus_ack:
  - bus_ack = 1 while IDLE with no requests.
  - Required: i_ack = d_ack = 0 and the state stays IDLE.
- Reset mid-transaction:
  - rst_n = 0 during GNT_D before bus_ack.
  - Required: bus_req = 0 in the same cycle, wait_cnt = 0. After release with d_req still high, bus_req re-asserts one cycle later.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch (I) and memory-stage (D) ports, D-priority with I anti-starvation
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic                stall_req_F,
    output logic                stall_req_M
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    state_t state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic starved, gnt_i, gnt_d;
    function automatic state_t arb(input logic i, input logic d, input logic s);
        return (d && !(i && s)) ? GNT_D : i ? GNT_I : IDLE;
    endfunction
    always_comb begin
        starved = wait_cnt >= WAIT_W'(MAX_WAIT);
        gnt_i = state == GNT_I;
        gnt_d = state == GNT_D;
        // completing port's request is masked so the other port is granted with no IDLE bubble
        state_nxt = state == IDLE ? arb(i_req, d_req, starved) :
                    !bus_ack      ? state :
                    gnt_i         ? arb(1'b0, d_req, starved) :
                                    arb(i_req, 1'b0, starved);
        bus_req     = gnt_i | gnt_d;
        bus_we      = gnt_d & d_we;
        bus_addr    = gnt_d ? d_addr : gnt_i ? i_addr : '0;
        bus_wdata   = gnt_d ? d_wdata : '0;
        bus_wstrb   = gnt_d ? d_wstrb : '0;
        i_ack       = gnt_i & bus_ack;
        d_ack       = gnt_d & bus_ack;
        i_rdata     = i_ack ? bus_rdata : '0;
        d_rdata     = d_ack ? bus_rdata : '0;
        stall_req_F = i_req & ~i_ack;
        stall_req_M = d_req & ~d_ack;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= gnt_i ? '0 : (i_req && wait_cnt != '1) ? wait_cnt + 1'b1 : wait_cnt;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven per-cycle vectors plus directed starvation and reset sequences
module tb_mem_bus_arbiter;
    localparam logic [31:0] IA = 32'h100, DA = 32'h2000, DW = 32'h55;
    localparam logic [3:0]  DS = 4'h1;
    logic clk = 0, rst_n = 0;
    logic i_req = 0, d_req = 0, d_we = 0, bus_ack = 0;
    logic [31:0] i_addr = IA, d_addr = DA, d_wdata = DW, bus_rdata = 0;
    logic [3:0] d_wstrb = DS;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0] bus_wstrb;
    logic i_ack, d_ack, bus_req, bus_we, stall_req_F, stall_req_M;
    int tests = 0, fails = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_req_F(stall_req_F), .stall_req_M(stall_req_M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic i, d, we, ack;
        logic [31:0] rdata;
        logic [1:0] gnt;
        logic ewe, eia, eda, esf, esm;
    } vec_t;

    function automatic logic [191:0] snap();
        return 192'({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, i_ack, i_rdata,
                     d_ack, d_rdata, stall_req_F, stall_req_M});
    endfunction

    function automatic logic [191:0] expect_of(input logic [1:0] g, input logic we, input logic ia,
                                               input logic da, input logic sf, input logic sm,
                                               input logic [31:0] rd);
        logic [31:0] a, w, ir, dr;
        logic [3:0] s;
        a  = g == 2'd1 ? IA : g == 2'd2 ? DA : 32'h0;
        w  = g == 2'd2 ? DW : 32'h0;
        s  = g == 2'd2 ? DS : 4'h0;
        ir = ia ? rd : 32'h0;
        dr = da ? rd : 32'h0;
        return 192'({g != 2'd0, we, a, w, s, ia, ir, da, dr, sf, sm});
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        i_req = 0; d_req = 0; d_we = 0; bus_ack = 0; bus_rdata = 0;
        tick();
        rst_n = 1;
    endtask

    vec_t vecs[15];
    int icyc, dacks, gcnt;

    initial begin
        // lone fetch (0-4), contention store (5-9), spurious ack (10-11), load (12-14)
        vecs[0]  = '{1,0,0,0,32'h0,        2'd0, 0,0,0,1,0};
        vecs[1]  = '{1,0,0,0,32'h0,        2'd1, 0,0,0,1,0};
        vecs[2]  = '{1,0,0,0,32'h0,        2'd1, 0,0,0,1,0};
        vecs[3]  = '{1,0,0,1,32'hDEADBEEF, 2'd1, 0,1,0,0,0};
        vecs[4]  = '{0,0,0,0,32'h0,        2'd0, 0,0,0,0,0};
        vecs[5]  = '{1,1,1,0,32'h0,        2'd0, 0,0,0,1,1};
        vecs[6]  = '{1,1,1,0,32'h0,        2'd2, 1,0,0,1,1};
        vecs[7]  = '{1,1,1,1,32'hCAFE0001, 2'd2, 1,0,1,1,0};
        vecs[8]  = '{1,0,0,0,32'h0,        2'd1, 0,0,0,1,0};
        vecs[9]  = '{1,0,0,1,32'hA5A5A5A5, 2'd1, 0,1,0,0,0};
        vecs[10] = '{0,0,0,1,32'hFFFFFFFF, 2'd0, 0,0,0,0,0};
        vecs[11] = '{0,0,0,0,32'h0,        2'd0, 0,0,0,0,0};
        vecs[12] = '{0,1,0,0,32'h0,        2'd0, 0,0,0,0,1};
        vecs[13] = '{0,1,0,1,32'h12345678, 2'd2, 0,0,1,0,0};
        vecs[14] = '{0,0,0,0,32'h0,        2'd0, 0,0,0,0,0};

        // outputs while held in reset, with spurious ack present
        i_req = 1; d_req = 1; bus_ack = 1;
        #2;
        chk("reset_outputs", snap(), expect_of(2'd0, 0, 0, 0, 1, 1, 32'h0));
        do_reset();

        for (int k = 0; k < 15; k++) begin
            i_req = vecs[k].i; d_req = vecs[k].d; d_we = vecs[k].we;
            bus_ack = vecs[k].ack; bus_rdata = vecs[k].rdata;
            #4;
            chk($sformatf("vec%0d", k), snap(),
                expect_of(vecs[k].gnt, vecs[k].ewe, vecs[k].eia, vecs[k].eda,
                          vecs[k].esf, vecs[k].esm, vecs[k].rdata));
            tick();
        end

        // both held, slave acks on the second cycle of every grant: I must follow the first D
        do_reset();
        i_req = 1; d_req = 1; d_we = 0; bus_rdata = 32'h0BADF00D;
        icyc = -1; dacks = 0; gcnt = 0;
        for (int c = 0; c < 8 && icyc < 0; c++) begin
            #1;
            bus_ack = bus_req && gcnt == 1;
            #3;
            if (d_ack) dacks++;
            if (i_ack) icyc = c;
            @(posedge clk);
            gcnt = bus_ack ? 0 : bus_req ? gcnt + 1 : 0;
            #1;
        end
        chk("starve_iack_cycle", 192'(icyc), 192'(4));
        chk("starve_dacks_before", 192'(dacks), 192'(1));

        // I accumulates 4 wait cycles behind a long D, then both request together from IDLE
        do_reset();
        d_req = 1; d_we = 1;
        tick();
        i_req = 1;
        for (int c = 0; c < 4; c++) tick();
        i_req = 0; bus_ack = 1;
        #4;
        chk("starve_d_done", 192'({d_ack, bus_req}), 192'({1'b1, 1'b1}));
        tick();
        bus_ack = 0; d_req = 0;
        #4;
        chk("starve_idle_gap", 192'(bus_req), 192'(0));
        tick();
        i_req = 1; d_req = 1;
        tick();
        #4;
        chk("starve_i_priority", 192'({bus_req, bus_we, bus_addr}), 192'({1'b1, 1'b0, IA}));

        // reset asserted during GNT_D with I waiting
        do_reset();
        i_req = 1; d_req = 1; d_we = 1;
        tick();
        tick();
        #1;
        chk("rst_pre_gnt_d", 192'({bus_req, bus_addr}), 192'({1'b1, DA}));
        rst_n = 0;
        #1;
        chk("rst_async_drop", 192'({bus_req, bus_we, d_ack, dut.wait_cnt}), 192'(0));
        tick();
        rst_n = 1;
        #3;
        chk("rst_release_idle", 192'(bus_req), 192'(0));
        tick();
        #3;
        chk("rst_regrant_d", 192'({bus_req, bus_we, bus_addr}), 192'({1'b1, 1'b1, DA}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
